// File: rtl/pa_run_scheduler.sv
// pa_run_scheduler: queues reconciled-key descriptors and runs privacy amplification one run at a time.
// Latency: start pulse 2 cycles after a push into an idle block; next start >= 2 cycles after the sk handshake.
// Backpressure: req_ready (registered) drops while the descriptor FIFO is full; sk_valid holds until sk_ready.
// Optional RUN watchdog enabled by defining PA_TIMEOUT_EN.
module pa_run_scheduler #(
   parameter int LEN_W          = 20,
   parameter int FIFO_DEPTH     = 2,
   parameter int MIN_LEN        = 64,
   parameter int TIMEOUT_CYCLES = 2000000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_index,
   input  logic [LEN_W-1:0] req_length,
   output logic             pa_start_compute,
   output logic             pa_key_addr_index,
   output logic [LEN_W-1:0] pa_secretkey_length,
   input  logic             pa_finish_compute,
   output logic             sk_valid,
   input  logic             sk_ready,
   output logic [LEN_W-1:0] sk_length,
   output logic             release_valid,
   output logic             release_index,
   output logic             len_err,
   output logic             busy,
   output logic [31:0]      total_sk_words,
   output logic             timeout_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LAUNCH  = 3'd1;
   localparam logic [2:0] ST_RUN     = 3'd2;
   localparam logic [2:0] ST_HANDOFF = 3'd3;
`ifdef PA_TIMEOUT_EN
   localparam logic [2:0] ST_TIMEOUT = 3'd4;
`endif

   logic [2:0]       state;
   logic [LEN_W-1:0] fifo_len [FIFO_DEPTH];
   logic             fifo_idx [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             ready_q;
   logic             push_hs;
   logic             len_bad;
   logic             push;
   logic             pop;
   logic             fin;
   logic             reject;
   logic             pend_vld;
   logic             pend_idx;
   logic [32:0]      words_sum;
   logic [31:0]      words_next;

   assign push_hs = req_valid && req_ready;
   assign len_bad = req_length < LEN_W'(MIN_LEN);
   assign push    = push_hs && !len_bad;
   assign reject  = push_hs && len_bad;
   assign pop     = (state == ST_IDLE) && (count != '0);
   assign fin     = (state == ST_RUN) && pa_finish_compute;

   assign pa_start_compute = (state == ST_LAUNCH);
   assign busy             = (state != ST_IDLE) || (count != '0);

   // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel out.
   always_comb begin
      count_next = count;
      if (push && !pop) begin
         count_next = count + 1'b1;
      end else if (!push && pop) begin
         count_next = count - 1'b1;
      end
   end

   // Saturating word total: each delivered key contributes length/64 whole words.
   always_comb begin
      words_sum  = {1'b0, total_sk_words} + 33'(pa_secretkey_length[LEN_W-1:6]);
      words_next = words_sum[32] ? 32'hFFFF_FFFF : words_sum[31:0];
   end

   // Descriptor storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_len[wr_ptr] <= req_length;
         fifo_idx[wr_ptr] <= req_index;
      end
   end

   // FIFO pointers, occupancy and the registered not-full flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count_next;
         ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
      end
   end

`ifdef PA_TIMEOUT_EN
   logic [31:0] wd_cnt;
   logic        timeout_hit;

   assign timeout_hit = (state == ST_RUN) && !pa_finish_compute &&
                        ((wd_cnt + 32'd1) == 32'(TIMEOUT_CYCLES));
   assign req_ready   = ready_q && (state != ST_TIMEOUT);

   // Watchdog counts RUN cycles since the last launch; the error flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (state == ST_LAUNCH) begin
            wd_cnt <= '0;
         end else if (state == ST_RUN) begin
            wd_cnt <= wd_cnt + 32'd1;
         end
         if (timeout_hit) timeout_err <= 1'b1;
      end
   end
`else
   assign req_ready   = ready_q;
   assign timeout_err = 1'b0;
`endif

   // Run sequencing: pop into the PA registers, pulse start, wait finish, hold the key for the consumer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state               <= ST_IDLE;
         pa_key_addr_index   <= 1'b0;
         pa_secretkey_length <= '0;
         sk_valid            <= 1'b0;
         sk_length           <= '0;
         total_sk_words      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  pa_key_addr_index   <= fifo_idx[rd_ptr];
                  pa_secretkey_length <= fifo_len[rd_ptr];
                  state               <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               state <= ST_RUN;
            end
            ST_RUN: begin
               if (pa_finish_compute) begin
                  sk_valid       <= 1'b1;
                  sk_length      <= {pa_secretkey_length[LEN_W-1:6], 6'b0};
                  total_sk_words <= words_next;
                  state          <= ST_HANDOFF;
               end
`ifdef PA_TIMEOUT_EN
               else if (timeout_hit) begin
                  state <= ST_TIMEOUT;
               end
`endif
            end
            ST_HANDOFF: begin
               if (sk_ready) begin
                  sk_valid <= 1'b0;
                  state    <= ST_IDLE;
               end
            end
`ifdef PA_TIMEOUT_EN
            ST_TIMEOUT: begin
               state <= ST_TIMEOUT;
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Release pulses: a run release wins; a colliding rejection waits one cycle in the holding register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         release_valid <= 1'b0;
         release_index <= 1'b0;
         len_err       <= 1'b0;
         pend_vld      <= 1'b0;
         pend_idx      <= 1'b0;
      end else begin
         release_valid <= 1'b0;
         len_err       <= 1'b0;
         if (fin) begin
            release_valid <= 1'b1;
            release_index <= pa_key_addr_index;
            if (reject) begin
               pend_vld <= 1'b1;
               pend_idx <= req_index;
            end
         end else if (pend_vld) begin
            release_valid <= 1'b1;
            release_index <= pend_idx;
            len_err       <= 1'b1;
            pend_vld      <= reject;
            if (reject) pend_idx <= req_index;
         end else if (reject) begin
            release_valid <= 1'b1;
            release_index <= req_index;
            len_err       <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pa_run_scheduler.sv
// Testbench for pa_run_scheduler: table of single-descriptor runs plus hand-written corner sequences.
// Expected launches, releases and delivered lengths are queued at drive time and popped by a negedge monitor.
// Responder and consumer processes model the PA engine and the secret-key reader.
module tb_pa_run_scheduler;
   localparam int LEN_W = 20;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_index = 1'b0;
   logic [LEN_W-1:0] req_length = '0;
   logic             pa_start_compute;
   logic             pa_key_addr_index;
   logic [LEN_W-1:0] pa_secretkey_length;
   logic             pa_finish_compute = 1'b0;
   logic             sk_valid;
   logic             sk_ready = 1'b0;
   logic [LEN_W-1:0] sk_length;
   logic             release_valid;
   logic             release_index;
   logic             len_err;
   logic             busy;
   logic [31:0]      total_sk_words;
   logic             timeout_err;

   always #5 clk = ~clk;

   pa_run_scheduler #(
      .LEN_W(LEN_W), .FIFO_DEPTH(2), .MIN_LEN(64), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_index(req_index), .req_length(req_length),
      .pa_start_compute(pa_start_compute), .pa_key_addr_index(pa_key_addr_index),
      .pa_secretkey_length(pa_secretkey_length), .pa_finish_compute(pa_finish_compute),
      .sk_valid(sk_valid), .sk_ready(sk_ready), .sk_length(sk_length),
      .release_valid(release_valid), .release_index(release_index), .len_err(len_err),
      .busy(busy), .total_sk_words(total_sk_words), .timeout_err(timeout_err)
   );

   typedef struct {
      logic             idx;
      logic [LEN_W-1:0] len;
      int               fin_dly;
      int               rdy_dly;
      logic             rej;
      logic [LEN_W-1:0] sk_len;
      int               words;
   } vec_t;

   typedef struct {
      logic             idx;
      logic [LEN_W-1:0] len;
      logic [LEN_W-1:0] sk_len;
      int               words;
   } run_t;

   typedef struct {
      logic idx;
      logic err;
   } rel_t;

   run_t             launch_q[$];
   rel_t             rel_q[$];
   logic [LEN_W-1:0] sk_q[$];
   run_t             cur_run;
   logic [LEN_W-1:0] cur_sk = '0;

   int  checks = 0;
   int  fails = 0;
   int  model_words = 0;
   int  cyc = 0;
   int  hs_cyc = -100;
   int  last_spacing = 0;
   int  fin_dly = 1;
   int  rdy_dly = 0;
   bit  hold_fin = 1'b0;
   bit  manual_fin = 1'b0;
   logic prev_start = 1'b0;
   logic prev_skv = 1'b0;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      fails++;
      $display("FAIL %s: event seen or bound expired, not expected", name);
   endtask

   always @(posedge clk) cyc++;

   // Monitor: compare every start, release and delivered key against the expectation queues.
   always @(negedge clk) begin
      if (pa_start_compute) begin
         check("start_width", prev_start, 0);
         last_spacing = cyc - hs_cyc;
         check("launch_spacing", 64'(last_spacing >= 2), 1);
         if (launch_q.size() == 0) begin
            flag("unexpected_start");
         end else begin
            cur_run = launch_q.pop_front();
            check("pa_index", pa_key_addr_index, cur_run.idx);
            check("pa_length", pa_secretkey_length, cur_run.len);
         end
      end
      if (release_valid) begin
         if (rel_q.size() == 0) begin
            flag("unexpected_release");
         end else begin
            rel_t r;
            r = rel_q.pop_front();
            check("release_index", release_index, r.idx);
            check("len_err", len_err, r.err);
         end
      end else if (len_err) begin
         flag("len_err_without_release");
      end
      if (sk_valid && !prev_skv) begin
         if (sk_q.size() == 0) begin
            flag("unexpected_sk_valid");
         end else begin
            cur_sk = sk_q.pop_front();
            check("sk_length", sk_length, cur_sk);
         end
      end else if (sk_valid) begin
         check("sk_length_hold", sk_length, cur_sk);
      end
      if (sk_valid && sk_ready) hs_cyc = cyc;
      prev_start = pa_start_compute;
      prev_skv   = sk_valid;
   end

   // PA engine model: finishes fin_dly cycles after each start unless the sequence drives finish itself.
   initial begin
      forever begin
         @(negedge clk);
         if (pa_start_compute && !manual_fin) begin
            while (hold_fin) @(posedge clk);
            repeat (fin_dly) @(posedge clk);
            #1;
            check("pa_index_stable", pa_key_addr_index, cur_run.idx);
            check("pa_length_stable", pa_secretkey_length, cur_run.len);
            rel_q.push_back('{cur_run.idx, 1'b0});
            sk_q.push_back(cur_run.sk_len);
            model_words += cur_run.words;
            pa_finish_compute = 1'b1;
            @(posedge clk);
            #1 pa_finish_compute = 1'b0;
         end
      end
   end

   // Key consumer: reads the BRAM rdy_dly cycles after sk_valid appears.
   initial begin
      forever begin
         @(negedge clk);
         if (sk_valid) begin
            repeat (rdy_dly) @(posedge clk);
            @(posedge clk);
            #1 sk_ready = 1'b1;
            @(posedge clk);
            #1 sk_ready = 1'b0;
         end
      end
   end

   task automatic push(input logic idx, input logic [LEN_W-1:0] len, input logic rej,
                       input logic [LEN_W-1:0] sk_len, input int words);
      bit done = 1'b0;
      req_valid  = 1'b1;
      req_index  = idx;
      req_length = len;
      for (int t = 0; t < 1000 && !done; t++) begin
         if (req_ready) begin
            done = 1'b1;
            if (rej) rel_q.push_back('{idx, 1'b1});
            else     launch_q.push_back('{idx, len, sk_len, words});
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      if (!done) flag("push_timeout");
   endtask

   task automatic wait_idle(input string name);
      bit done = 1'b0;
      for (int t = 0; t < 3000 && !done; t++) begin
         @(posedge clk);
         #1;
         if (!busy && !sk_valid && !pa_finish_compute && launch_q.size() == 0 &&
             rel_q.size() == 0 && sk_q.size() == 0) done = 1'b1;
      end
      if (!done) flag(name);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string name);
      bit done = 1'b0;
      for (int t = 0; t < 500 && !done; t++) begin
         @(negedge clk);
         if (pa_start_compute) done = 1'b1;
      end
      if (!done) flag(name);
   endtask

   initial begin
      int start_cyc;
      bit seen;

      vecs[0] = '{1'b1, 20'd1088,     50, 0, 1'b0, 20'd1088,     17};
      vecs[1] = '{1'b0, 20'd40,       1,  0, 1'b1, 20'd0,        0};
      vecs[2] = '{1'b0, 20'd64,       1,  0, 1'b0, 20'd64,       1};
      vecs[3] = '{1'b1, 20'd63,       1,  0, 1'b1, 20'd0,        0};
      vecs[4] = '{1'b0, 20'd127,      2,  3, 1'b0, 20'd64,       1};
      vecs[5] = '{1'b1, 20'hFFFFF,    4,  1, 1'b0, 20'hFFFC0,    16383};
      vecs[6] = '{1'b1, 20'd0,        1,  0, 1'b1, 20'd0,        0};
      vecs[7] = '{1'b0, 20'd1000,     7,  5, 1'b0, 20'd960,      15};

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_req_ready", req_ready, 1);
      check("rst_start", pa_start_compute, 0);
      check("rst_pa_index", pa_key_addr_index, 0);
      check("rst_pa_length", pa_secretkey_length, 0);
      check("rst_sk_valid", sk_valid, 0);
      check("rst_sk_length", sk_length, 0);
      check("rst_release", release_valid, 0);
      check("rst_release_index", release_index, 0);
      check("rst_len_err", len_err, 0);
      check("rst_busy", busy, 0);
      check("rst_total", total_sk_words, 0);
      check("rst_timeout_err", timeout_err, 0);

      // Table of single-descriptor runs and rejections
      for (int i = 0; i < 8; i++) begin
         fin_dly = vecs[i].fin_dly;
         rdy_dly = vecs[i].rdy_dly;
         push(vecs[i].idx, vecs[i].len, vecs[i].rej, vecs[i].sk_len, vecs[i].words);
         wait_idle("vec_idle_timeout");
         check("vec_total_words", total_sk_words, model_words);
         check("vec_busy", busy, 0);
         check("vec_req_ready", req_ready, 1);
      end
      check("table_total_words", total_sk_words, 16417);

      // Back-to-back pushes with PA stalled: FIFO fills, ready returns after the next pop
      fin_dly  = 3;
      rdy_dly  = 0;
      hold_fin = 1'b1;
      push(1'b0, 20'd640, 1'b0, 20'd640, 10);
      push(1'b1, 20'd320, 1'b0, 20'd320, 5);
      push(1'b0, 20'd130, 1'b0, 20'd128, 2);
      check("full_ready_low", req_ready, 0);
      repeat (10) @(posedge clk);
      #1;
      check("full_ready_held", req_ready, 0);
      check("full_busy", busy, 1);
      hold_fin = 1'b0;
      fork
         push(1'b1, 20'd70, 1'b0, 20'd64, 1);
         begin
            wait_start("second_start_timeout");
            check("ready_after_pop", req_ready, 1);
         end
      join
      wait_idle("b2b_idle_timeout");
      check("b2b_total_words", total_sk_words, model_words);

      // Consumer stalls 100 cycles with a descriptor queued behind
      rdy_dly = 100;
      fin_dly = 5;
      push(1'b0, 20'd256, 1'b0, 20'd256, 4);
      push(1'b1, 20'd200, 1'b0, 20'd192, 3);
      wait_idle("stall_idle_timeout");
      check("stall_spacing_exact", last_spacing, 2);
      rdy_dly = 0;

      // Rejection colliding with a run finish: run release first, rejection one cycle later
      manual_fin = 1'b1;
      push(1'b1, 20'd512, 1'b0, 20'd512, 8);
      wait_start("collide_start_timeout");
      repeat (3) @(posedge clk);
      #1;
      check("collide_req_ready", req_ready, 1);
      rel_q.push_back('{1'b1, 1'b0});
      rel_q.push_back('{1'b0, 1'b1});
      sk_q.push_back(20'd512);
      model_words += 8;
      pa_finish_compute = 1'b1;
      req_valid  = 1'b1;
      req_index  = 1'b0;
      req_length = 20'd10;
      @(posedge clk);
      #1;
      pa_finish_compute = 1'b0;
      req_valid = 1'b0;
      check("collide_first_release", release_valid, 1);
      check("collide_first_len_err", len_err, 0);
      @(posedge clk);
      #1;
      check("collide_second_len_err", len_err, 1);
      wait_idle("collide_idle_timeout");
      check("collide_total_words", total_sk_words, model_words);

      // Finish and sk_ready while idle are ignored
      pa_finish_compute = 1'b1;
      sk_ready = 1'b1;
      @(posedge clk);
      #1;
      pa_finish_compute = 1'b0;
      sk_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_fin_sk_valid", sk_valid, 0);
      check("idle_fin_busy", busy, 0);
      check("idle_fin_total", total_sk_words, model_words);

      // Reset in the middle of a run abandons it silently
      push(1'b0, 20'd128, 1'b0, 20'd128, 2);
      wait_start("reset_run_start_timeout");
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      model_words = 0;
      pa_finish_compute = 1'b1;
      @(posedge clk);
      #1 pa_finish_compute = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("mid_rst_req_ready", req_ready, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_sk_valid", sk_valid, 0);
      check("mid_rst_start", pa_start_compute, 0);
      check("mid_rst_pa_index", pa_key_addr_index, 0);
      check("mid_rst_pa_length", pa_secretkey_length, 0);
      check("mid_rst_total", total_sk_words, 0);
      check("mid_rst_release", release_valid, 0);

`ifdef PA_TIMEOUT_EN
      // Watchdog: finish never arrives
      push(1'b1, 20'd64, 1'b0, 20'd64, 1);
      wait_start("timeout_start_timeout");
      start_cyc = cyc;
      seen = 1'b0;
      for (int t = 0; t < 300 && !seen; t++) begin
         @(negedge clk);
         if (timeout_err) seen = 1'b1;
      end
      if (!seen) flag("timeout_never_set");
      check("timeout_cycle", cyc - start_cyc, 101);
      check("timeout_req_ready", req_ready, 0);
      check("timeout_busy", busy, 1);
      repeat (20) @(posedge clk);
      #1 pa_finish_compute = 1'b1;
      @(posedge clk);
      #1 pa_finish_compute = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("timeout_sticky", timeout_err, 1);
      check("timeout_ready_held", req_ready, 0);
      check("timeout_no_sk", sk_valid, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      check("timeout_cleared", timeout_err, 0);
      check("timeout_rst_ready", req_ready, 1);
`else
      start_cyc = cyc;
      seen = 1'b0;
      check("no_watchdog_timeout_err", timeout_err, 0);
`endif
      manual_fin = 1'b0;

      check("launch_q_empty", launch_q.size(), 0);
      check("rel_q_empty", rel_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation bound expired");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/pa_run_scheduler.md
Name: pa_run_scheduler

Overview:
- Sequences privacy-amplification (PA) runs on the single PA datapath.
- Upstream reconciliation pushes completed reconciled-key descriptors: half-index of the key BRAM plus secret key length. The block queues them and launches one PA run at a time with a one-cycle start pulse.
- Waits for PA finish, then hands ownership of the secret key BRAM contents to a downstream consumer via valid/ready.
- Releases the consumed key-BRAM half back to reconciliation.

Parameters:
- LEN_W, 20, width of secret key length fields.
- FIFO_DEPTH, 2, descriptor queue depth. Power of 2, 2..8.
- MIN_LEN, 64, smallest accepted secret key length in bits.
- TIMEOUT_CYCLES, 2000000, RUN-state watchdog limit. Used only with PA_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  descriptor offered by reconciliation
- req_ready  out  1  descriptor accepted when req_valid&&req_ready
- req_index  in  1  key BRAM half (0: addr 0..16383, 1: addr 16384..32767)
- req_length  in  LEN_W  requested secret key length in bits
- pa_start_compute  out  1  one-cycle start pulse to PA
- pa_key_addr_index  out  1  half-index for the PA run; stable from the start pulse until finish
- pa_secretkey_length  out  LEN_W  length for the PA run; stable from the start pulse until finish
- pa_finish_compute  in  1  one-cycle PA done pulse
- sk_valid  out  1  secret key BRAM holds a finished key
- sk_ready  in  1  consumer has read the secret key BRAM
- sk_length  out  LEN_W  delivered bits, i.e. {length[LEN_W-1:6],6'b0}
- release_valid  out  1  one-cycle pulse: key-BRAM half is free
- release_index  out  1  half being released
- len_err  out  1  one-cycle pulse: descriptor rejected
- busy  out  1  state != IDLE or FIFO non-empty
- total_sk_words  out  32  saturating count of delivered 64-bit words
- timeout_err  out  1  sticky watchdog flag. Constant 0 without PA_TIMEOUT_EN.

Behaviour:
- Reset (synchronous, rst_n=0 at posedge clk):
  - FIFO emptied; state=IDLE.
  - All outputs 0, except req_ready=1 after reset deasserts.
  - total_sk_words=0.
  - Reset mid-run abandons the run silently: no release_valid, no sk_valid.
- FIFO:
  - req_ready = !full, registered from the occupancy count.
  - A push is accepted while full only if req_ready was already 1; there is no same-cycle pass-through on pop.
  - Push and pop in the same cycle keep the count unchanged.
- Validation at push:
  - If req_length < MIN_LEN, the descriptor is not queued.
  - Next cycle: len_err=1, release_valid=1, release_index=req_index.
- FSM states: IDLE, LAUNCH, RUN, HANDOFF, plus TIMEOUT when PA_TIMEOUT_EN is defined.
  - IDLE -> LAUNCH when the FIFO is non-empty. The head is popped into the pa_* registers on the same edge.
  - LAUNCH: pa_start_compute=1 for exactly one cycle -> RUN.
  - RUN: on pa_finish_compute -> HANDOFF. Same edge:
    - sk_valid<=1 and sk_length<=rounded length.
    - release_valid pulse with release_index=pa_key_addr_index.
    - total_sk_words += length>>6, saturating at 0xFFFFFFFF.
  - HANDOFF: sk_valid held with sk_length stable until sk_ready=1. Then sk_valid<=0 and -> IDLE.
  - sk_ready while sk_valid=0 is ignored.
- Minimum spacing: next pa_start_compute occurs no earlier than 2 cycles after the sk_valid&&sk_ready handshake, so the secret key BRAM is never overwritten before it is consumed.
- pa_finish_compute outside RUN is ignored.
- release_valid collision: a length rejection and a run finish in the same cycle both need a release pulse. The run release goes out first; the rejection release and len_err are delayed one cycle through a 1-entry holding register. Only one pending rejection can exist, because a push needs a cycle.
- pa_key_addr_index and pa_secretkey_length retain their last value when idle.

Optional Feature:
- Macro PA_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on LAUNCH and counts in RUN.
  - When it reaches TIMEOUT_CYCLES without a finish, the FSM enters TIMEOUT and timeout_err is set (sticky).
  - In TIMEOUT: req_ready=0, no further launches, no release pulse. Exit only by reset.
- Undefined: no counter, no TIMEOUT state, timeout_err tied 0. RUN waits indefinitely.

Test Plan:
- Push {index=1, length=1088}; finish 50 cycles after start -> single start pulse with index=1, length=1088; sk_length=1088, release_index=1, total_sk_words=17.
- Push 3 descriptors back-to-back with no finish -> req_ready drops after 2 accepted, returns 1 cycle after the first pop; third accepted then; runs launch in order.
- Push length=40 -> no start pulse, len_err and release_valid pulse with its index next cycle; FIFO count unchanged.
- Hold sk_ready=0 for 100 cycles after finish with a queued descriptor -> no start pulse until 2 cycles after sk_ready handshake.
- Assert rst_n=0 during RUN, then finish pulse after reset -> outputs all zero, finish ignored, state IDLE, req_ready=1.
- PA_TIMEOUT_EN with TIMEOUT_CYCLES=100, finish never arrives -> timeout_err=1 at cycle 100 of RUN, req_ready=0, stays until reset.
